// File: rtl/fetch_unit.sv
// Instruction fetch stage: writable program memory, PC sequencing with run control,
// programme length, jumps, and a registered valid/ready instruction slot.
module fetch_unit #(
   parameter int INSTR_W = 12,
   parameter int DEPTH   = 16,
   parameter int ADDR_W  = $clog2(DEPTH)
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_load_en,
   input  logic [ADDR_W-1:0]  i_load_addr,
   input  logic [INSTR_W-1:0] i_load_data,
   input  logic [ADDR_W:0]    i_prog_len,
   input  logic               i_start,
   input  logic               i_stop,
   input  logic               i_jump_en,
   input  logic [ADDR_W-1:0]  i_jump_addr,
   output logic [INSTR_W-1:0] o_instruction,
   output logic               o_instr_valid,
   input  logic               i_instr_ready,
   output logic [ADDR_W-1:0]  o_pc,
   output logic               o_busy,
   output logic               o_done
);

   localparam int LEN_W = ADDR_W + 1;
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               r_state;
   logic [ADDR_W-1:0]    r_pc;
   logic [INSTR_W-1:0]   r_instr;
   logic                 r_valid;
   logic [LEN_W-1:0]     r_len;
   logic [INSTR_W-1:0]   r_mem [DEPTH];

   state_t               w_state_next;
   logic [ADDR_W-1:0]    w_pc_next;
   logic [INSTR_W-1:0]   w_instr_next;
   logic                 w_valid_next;
   logic [LEN_W-1:0]     w_len_next;
   logic [LEN_W-1:0]     w_len_clamped;
   logic                 w_slot_free;
   logic                 w_load_ok;
   logic [INSTR_W-1:0]   w_fetch_word;

   assign w_slot_free   = !r_valid || i_instr_ready;
   assign w_len_clamped = (i_prog_len > MAX_LEN) ? MAX_LEN : i_prog_len;
   assign w_load_ok     = i_load_en && (r_state != ST_RUN) && !i_reset;
   assign w_fetch_word  = r_mem[r_pc];

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_instr_next = r_instr;
      w_valid_next = r_valid;
      w_len_next   = r_len;

      unique case (r_state)
         ST_IDLE, ST_DONE: begin
            // A word left over from the previous run stays offered until taken.
            if (r_valid && i_instr_ready) w_valid_next = 1'b0;
            if (i_start) begin
               w_len_next   = w_len_clamped;
               w_pc_next    = '0;
               w_state_next = (w_len_clamped == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (i_jump_en) begin
               w_valid_next = 1'b0;
               w_pc_next    = i_jump_addr;
               if ({1'b0, i_jump_addr} >= r_len) w_state_next = ST_DONE;
            end else if (!i_stop && w_slot_free) begin
               w_instr_next = w_fetch_word;
               w_valid_next = 1'b1;
               w_pc_next    = r_pc + 1'b1;
               if ({1'b0, r_pc} == r_len - 1'b1) w_state_next = ST_DONE;
            end else if (r_valid && i_instr_ready) begin
               w_valid_next = 1'b0;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_pc    <= '0;
         r_instr <= '0;
         r_valid <= 1'b0;
         r_len   <= '0;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         r_instr <= w_instr_next;
         r_valid <= w_valid_next;
         r_len   <= w_len_next;
      end
   end

   // NOTE: program memory is deliberately not reset so a loaded programme survives reset.
   always_ff @(posedge i_clk) begin
      if (w_load_ok) r_mem[i_load_addr] <= i_load_data;
   end

   assign o_instruction = r_instr;
   assign o_instr_valid = r_valid;
   assign o_pc          = r_pc;
   assign o_busy        = (r_state == ST_RUN);
   assign o_done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: each task drives one scenario and compares a snapshot
// {valid, busy, done, pc, instruction} against hand-computed values.
module tb_fetch_unit;

   localparam int INSTR_W = 12;
   localparam int DEPTH   = 16;
   localparam int ADDR_W  = 4;

   logic               clk = 1'b0;
   logic               reset;
   logic               load_en;
   logic [ADDR_W-1:0]  load_addr;
   logic [INSTR_W-1:0] load_data;
   logic [ADDR_W:0]    prog_len;
   logic               start;
   logic               stop;
   logic               jump_en;
   logic [ADDR_W-1:0]  jump_addr;
   logic [INSTR_W-1:0] instruction;
   logic               instr_valid;
   logic               instr_ready;
   logic [ADDR_W-1:0]  pc;
   logic               busy;
   logic               done;

   int n_compared   = 0;
   int n_mismatched = 0;

   always #5 clk = ~clk;

   fetch_unit #(.INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_load_en    (load_en),
      .i_load_addr  (load_addr),
      .i_load_data  (load_data),
      .i_prog_len   (prog_len),
      .i_start      (start),
      .i_stop       (stop),
      .i_jump_en    (jump_en),
      .i_jump_addr  (jump_addr),
      .o_instruction(instruction),
      .o_instr_valid(instr_valid),
      .i_instr_ready(instr_ready),
      .o_pc         (pc),
      .o_busy       (busy),
      .o_done       (done)
   );

   typedef logic [18:0] snap_t;

   function automatic snap_t observed();
      return {instr_valid, busy, done, pc, instruction};
   endfunction

   function automatic snap_t expect_snap(input logic v, input logic b, input logic d,
                                         input logic [3:0] p, input logic [11:0] w);
      return {v, b, d, p, w};
   endfunction

   // One clock edge; outputs are then sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [3:0] a, input logic [11:0] d);
      load_en = 1'b1; load_addr = a; load_data = d;
      tick();
      load_en = 1'b0;
   endtask

   task automatic start_run(input logic [4:0] len);
      prog_len = len; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      snap_t exp;
      reset = 1'b1; start = 1'b1; prog_len = 5'd3;
      tick(); tick();
      exp = expect_snap(0, 0, 0, 4'd0, 12'h000);
      n_compared++;
      if (observed() !== exp) begin
         n_mismatched++;
         $display("FAIL reset_state: got %h want %h", observed(), exp);
      end
      reset = 1'b0; start = 1'b0;
      tick();
      n_compared++;
      if (observed() !== exp) begin
         n_mismatched++;
         $display("FAIL reset_idle_hold: got %h want %h", observed(), exp);
      end
   endtask

   task automatic test_basic_run();
      snap_t exp [5];
      load_word(4'd0, 12'h100);
      load_word(4'd1, 12'h100);
      load_word(4'd2, 12'h200);
      instr_ready = 1'b1;
      exp[0] = expect_snap(0, 1, 0, 4'd0, 12'h000);
      exp[1] = expect_snap(1, 1, 0, 4'd1, 12'h100);
      exp[2] = expect_snap(1, 1, 0, 4'd2, 12'h100);
      exp[3] = expect_snap(1, 0, 1, 4'd3, 12'h200);
      exp[4] = expect_snap(0, 0, 1, 4'd3, 12'h200);
      start_run(5'd3);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) tick();
         n_compared++;
         if (observed() !== exp[i]) begin
            n_mismatched++;
            $display("FAIL basic_run step %0d: got %h want %h", i, observed(), exp[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      snap_t exp;
      instr_ready = 1'b1;
      start_run(5'd3);
      tick();
      instr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         exp = expect_snap(1, 1, 0, 4'd1, 12'h100);
         n_compared++;
         if (observed() !== exp) begin
            n_mismatched++;
            $display("FAIL backpressure_hold %0d: got %h want %h", i, observed(), exp);
         end
      end
      instr_ready = 1'b1;
      tick();
      exp = expect_snap(1, 1, 0, 4'd2, 12'h100);
      n_compared++;
      if (observed() !== exp) begin
         n_mismatched++;
         $display("FAIL backpressure_release: got %h want %h", observed(), exp);
      end
      tick();
      exp = expect_snap(1, 0, 1, 4'd3, 12'h200);
      n_compared++;
      if (observed() !== exp) begin
         n_mismatched++;
         $display("FAIL backpressure_last: got %h want %h", observed(), exp);
      end
      tick();
   endtask

   task automatic test_stop();
      snap_t exp;
      instr_ready = 1'b1;
      start_run(5'd3);
      tick();
      stop = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         exp = expect_snap(0, 1, 0, 4'd1, 12'h100);
         n_compared++;
         if (observed() !== exp) begin
            n_mismatched++;
            $display("FAIL stop_stall %0d: got %h want %h", i, observed(), exp);
         end
      end
      stop = 1'b0;
      tick();
      exp = expect_snap(1, 1, 0, 4'd2, 12'h100);
      n_compared++;
      if (observed() !== exp) begin
         n_mismatched++;
         $display("FAIL stop_resume: got %h want %h", observed(), exp);
      end
      tick();
      exp = expect_snap(1, 0, 1, 4'd3, 12'h200);
      n_compared++;
      if (observed() !== exp) begin
         n_mismatched++;
         $display("FAIL stop_last: got %h want %h", observed(), exp);
      end
      tick();
   endtask

   task automatic test_jump();
      snap_t exp;
      for (int i = 0; i < 8; i++) load_word(4'(i), 12'hA00 + 12'(i));
      instr_ready = 1'b1;
      start_run(5'd8);
      tick(); tick(); tick();
      exp = expect_snap(1, 1, 0, 4'd3, 12'hA02);
      n_compared++;
      if (observed() !== exp) begin
         n_mismatched++;
         $display("FAIL jump_pre: got %h want %h", observed(), exp);
      end
      jump_en = 1'b1; jump_addr = 4'd5;
      tick();
      jump_en = 1'b0;
      exp = expect_snap(0, 1, 0, 4'd5, 12'hA02);
      n_compared++;
      if (observed() !== exp) begin
         n_mismatched++;
         $display("FAIL jump_flush: got %h want %h", observed(), exp);
      end
      tick();
      exp = expect_snap(1, 1, 0, 4'd6, 12'hA05);
      n_compared++;
      if (observed() !== exp) begin
         n_mismatched++;
         $display("FAIL jump_target: got %h want %h", observed(), exp);
      end
      jump_en = 1'b1; jump_addr = 4'd9;
      tick();
      exp = expect_snap(0, 0, 1, 4'd9, 12'hA05);
      n_compared++;
      if (observed() !== exp) begin
         n_mismatched++;
         $display("FAIL jump_out_of_range: got %h want %h", observed(), exp);
      end
      jump_addr = 4'd3;
      tick();
      jump_en = 1'b0;
      n_compared++;
      if (observed() !== exp) begin
         n_mismatched++;
         $display("FAIL jump_ignored_in_done: got %h want %h", observed(), exp);
      end
   endtask

   task automatic test_reset_mid_run();
      snap_t exp;
      instr_ready = 1'b1;
      start_run(5'd8);
      tick(); tick();
      load_en = 1'b1; load_addr = 4'd0; load_data = 12'hFFF;
      tick();
      load_en = 1'b0;
      exp = expect_snap(1, 1, 0, 4'd3, 12'hA02);
      n_compared++;
      if (observed() !== exp) begin
         n_mismatched++;
         $display("FAIL run_with_load: got %h want %h", observed(), exp);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp = expect_snap(0, 0, 0, 4'd0, 12'h000);
      n_compared++;
      if (observed() !== exp) begin
         n_mismatched++;
         $display("FAIL reset_mid_run: got %h want %h", observed(), exp);
      end
      start_run(5'd2);
      tick();
      exp = expect_snap(1, 1, 0, 4'd1, 12'hA00);
      n_compared++;
      if (observed() !== exp) begin
         n_mismatched++;
         $display("FAIL replay_word0: got %h want %h", observed(), exp);
      end
      tick();
      exp = expect_snap(1, 0, 1, 4'd2, 12'hA01);
      n_compared++;
      if (observed() !== exp) begin
         n_mismatched++;
         $display("FAIL replay_word1: got %h want %h", observed(), exp);
      end
      tick();
   endtask

   task automatic test_zero_length();
      snap_t exp;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      start_run(5'd0);
      exp = expect_snap(0, 0, 1, 4'd0, 12'h000);
      n_compared++;
      if (observed() !== exp) begin
         n_mismatched++;
         $display("FAIL zero_len_done: got %h want %h", observed(), exp);
      end
      tick();
      n_compared++;
      if (observed() !== exp) begin
         n_mismatched++;
         $display("FAIL zero_len_no_valid: got %h want %h", observed(), exp);
      end
      load_word(4'd0, 12'h5A5);
      load_word(4'd1, 12'h0F0);
      instr_ready = 1'b1;
      start_run(5'd2);
      tick();
      exp = expect_snap(1, 1, 0, 4'd1, 12'h5A5);
      n_compared++;
      if (observed() !== exp) begin
         n_mismatched++;
         $display("FAIL rerun_word0: got %h want %h", observed(), exp);
      end
      tick();
      exp = expect_snap(1, 0, 1, 4'd2, 12'h0F0);
      n_compared++;
      if (observed() !== exp) begin
         n_mismatched++;
         $display("FAIL rerun_word1: got %h want %h", observed(), exp);
      end
      tick();
      exp = expect_snap(0, 0, 1, 4'd2, 12'h0F0);
      n_compared++;
      if (observed() !== exp) begin
         n_mismatched++;
         $display("FAIL rerun_drain: got %h want %h", observed(), exp);
      end
   endtask

   initial begin
      reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
      prog_len = '0; start = 1'b0; stop = 1'b0; jump_en = 1'b0;
      jump_addr = '0; instr_ready = 1'b0;
      test_reset();
      test_basic_run();
      test_backpressure();
      test_stop();
      test_jump();
      test_reset_mid_run();
      test_zero_length();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
